// File: rtl/cb_addr_gen_pkg.sv
// cb_pkg: shared FSM encoding, default geometry and group/mask helpers for cb_addr_gen.
package cb_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam int unsigned L_DEF = 4;
    localparam int unsigned CB_AW_DEF = 19;
    localparam int unsigned ROW_LEN_DEF = 10;
    function automatic int unsigned ceil_div_l(input int unsigned col_num);
        return (col_num + L_DEF - 1) / L_DEF;
    endfunction
    function automatic logic [L_DEF-1:0] tail_mask(input int unsigned rem);
        logic [L_DEF-1:0] m;
        m = '1;
        if (rem != 0) m = L_DEF'((32'd1 << rem) - 32'd1);
        return m;
    endfunction
endpackage

// File: rtl/cb_addr_gen_tail_mask.sv
// cb_tail_mask: group count and last-group bank mask for a row of col_num elements.
module cb_tail_mask
    import cb_pkg::*;
#(
    parameter int CW = 12,
    parameter int ROW_LEN = 10,
    parameter int GW = 4
) (
    input  logic [CW-1:0]    col_num,
    output logic [GW-1:0]    ngrp,
    output logic [L_DEF-1:0] mask
);
    localparam int unsigned MAXC = ROW_LEN * L_DEF;
    logic [CW-1:0] col_sat;
    // Rows wider than the matrix are clipped to a full row
    assign col_sat = (col_num > CW'(MAXC)) ? CW'(MAXC) : col_num;
    assign ngrp = GW'(ceil_div_l(32'(col_sat)));
    assign mask = tail_mask(32'(col_sat) % L_DEF);
endmodule

// File: rtl/cb_addr_gen.sv
// cb_addr_gen: walks a CB sub-block row by row, one L-bank group per cycle.
// Optional CB_ADDR_GEN_STALL_EN adds a stall input that freezes issue in RUN.
module cb_addr_gen
    import cb_pkg::*;
#(
    parameter int L = L_DEF,
    parameter int CB_AW = CB_AW_DEF,
    parameter int ROW_LEN = ROW_LEN_DEF,
    parameter int RW = 10,
    parameter int CW = 12
) (
`ifdef CB_ADDR_GEN_STALL_EN
    input  logic             stall,
`endif
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [CB_AW-1:0] base_addr,
    input  logic [RW-1:0]    row_num,
    input  logic [CW-1:0]    col_num,
    output logic             busy,
    output logic             done,
    output logic [CB_AW-1:0] dout,
    output logic [L-1:0]     CB_en,
    output logic             group_cnt_0
);
    localparam int GW = $clog2(ROW_LEN + 1);
    state_t state, nxt;
    logic [CB_AW-1:0] row_addr;
    logic [GW-1:0] grp, ngrp, ngrp_c;
    logic [RW-1:0] row, nrow;
    logic [L-1:0] mask, mask_c;
    logic hold, adv, last_grp, last_row, accept;

`ifdef CB_ADDR_GEN_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    cb_tail_mask #(.CW(CW), .ROW_LEN(ROW_LEN), .GW(GW)) u_tail (
        .col_num(col_num),
        .ngrp(ngrp_c),
        .mask(mask_c)
    );

    always_comb begin
        accept = (state == IDLE) && start;
        adv = (state == RUN) && !hold;
        last_grp = grp == ngrp - GW'(1);
        last_row = row == nrow - RW'(1);
        nxt = accept ? ((row_num == '0 || col_num == '0) ? FIN : RUN) :
              (adv && last_grp && last_row) ? FIN :
              (state == FIN) ? IDLE : state;
        dout = row_addr + CB_AW'(grp);
        CB_en = adv ? (last_grp ? mask : '1) : '0;
        group_cnt_0 = (state == RUN) && (grp == '0);
    end

    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            row_addr <= '0;
            grp <= '0;
            ngrp <= '0;
            row <= '0;
            nrow <= '0;
            mask <= '0;
        end else begin
            state <= nxt;
            busy <= nxt != IDLE;
            done <= state == FIN;
            if (accept) begin
                row_addr <= base_addr;
                grp <= '0;
                row <= '0;
                nrow <= row_num;
                ngrp <= ngrp_c;
                mask <= mask_c;
            end else if (adv && last_grp) begin
                grp <= '0;
                row_addr <= row_addr + CB_AW'(ROW_LEN);
                row <= row + RW'(1);
            end else if (adv) begin
                grp <= grp + GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_cb_addr_gen.sv
// tb_cb_addr_gen: scoreboard bench; a reference walk of the sub-block fills the
// expected queue, a monitor pops it on every issue cycle.
module tb_cb_addr_gen;
    logic clk = 0, sys_rst = 0, start = 0, stall = 0;
    logic [18:0] base_addr = '0;
    logic [9:0] row_num = '0;
    logic [11:0] col_num = '0;
    logic busy, done, group_cnt_0;
    logic [18:0] dout;
    logic [3:0] CB_en;
    typedef struct {logic [18:0] a; logic [3:0] en; logic g0;} item_t;
    item_t q[$];
    int tests = 0, fails = 0;
    bit stall_mode = 0;

    always #5 clk = ~clk;

    cb_addr_gen dut (
`ifdef CB_ADDR_GEN_STALL_EN
        .stall(stall),
`endif
        .clk(clk), .sys_rst(sys_rst), .start(start), .base_addr(base_addr),
        .row_num(row_num), .col_num(col_num), .busy(busy), .done(done),
        .dout(dout), .CB_en(CB_en), .group_cnt_0(group_cnt_0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: every group of every row, in issue order; returns issue count
    function automatic int expect_walk(input logic [18:0] b, input int r, input int c);
        int cs, ng, rem;
        logic [3:0] m;
        logic [18:0] a;
        cs = (c > 40) ? 40 : c;
        ng = (cs + 3) / 4;
        rem = cs % 4;
        m = (rem == 0) ? 4'hF : (4'hF >> (4 - rem));
        if (r == 0 || c == 0) return 0;
        for (int rr = 0; rr < r; rr++)
            for (int g = 0; g < ng; g++) begin
                a = b + 19'(rr * 10 + g);
                q.push_back('{a, (g == ng - 1) ? m : 4'hF, g == 0});
            end
        return r * ng;
    endfunction

    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (stall && CB_en !== 4'b0) check("cb_en_during_stall", CB_en, 0);
            if (CB_en !== 4'b0) begin
                if (q.size() == 0) check("unexpected_issue", CB_en, 0);
                else begin
                    e = q.pop_front();
                    check("dout", dout, e.a);
                    check("cb_en", CB_en, e.en);
                    check("group_cnt_0", group_cnt_0, e.g0);
                end
            end
        end
    end

    task automatic txn(input logic [18:0] b, input int r, input int c,
                       input int stall_rate, input int stall_from, input int stall_len);
        int n, k, stalls, busy_cyc;
        n = expect_walk(b, r, c);
        stalls = 0;
        busy_cyc = 0;
        @(posedge clk); #1;
        base_addr = b; row_num = 10'(r); col_num = 12'(c); start = 1;
        for (k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            start = 0;
            stall = stall_mode && ((k >= stall_from && k < stall_from + stall_len) ||
                                   ($urandom_range(99) < 32'(stall_rate)));
            if (stall && q.size() > 0) stalls++;
            @(negedge clk);
            if (done) break;
            busy_cyc += int'(busy);
        end
        stall = 0;
        check("done_latency", k, n + stalls + 2);
        check("busy_cycles", busy_cyc, n + stalls + 1);
        check("busy_at_done", busy, 0);
        check("queue_drained", q.size(), 0);
        @(negedge clk);
        check("done_width", done, 0);
        q.delete();
    endtask

    initial begin
        int n, dn;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_cb_en", CB_en, 0);
        check("rst_g0", group_cnt_0, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        sys_rst = 1;
        txn(19'd100, 2, 6, 0, 0, 0);
        txn(19'd0, 3, 4, 0, 0, 0);
        txn(19'd5, 0, 7, 0, 0, 0);
        txn(19'd5, 3, 0, 0, 0, 0);
        txn(19'h7FFFF, 1, 8, 0, 0, 0);
        txn(19'd40, 2, 45, 0, 0, 0);
        // Abort during the second issue cycle
        n = expect_walk(19'd100, 2, 6);
        @(posedge clk); #1;
        base_addr = 19'd100; row_num = 10'd2; col_num = 12'd6; start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        sys_rst = 0;
        @(posedge clk); #1;
        sys_rst = 1;
        check("abort_pending", q.size(), n - 2);
        q.delete();
        @(negedge clk);
        check("abort_dout", dout, 0);
        check("abort_cb_en", CB_en, 0);
        check("abort_g0", group_cnt_0, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            dn += int'(done);
        end
        check("abort_no_done", dn, 0);
        txn(19'd7, 1, 3, 0, 0, 0);
`ifdef CB_ADDR_GEN_STALL_EN
        stall_mode = 1;
        txn(19'd100, 2, 6, 0, 2, 3);
`endif
        for (int i = 0; i < 12; i++)
            txn(19'($urandom), int'($urandom_range(4)), int'($urandom_range(50)),
                stall_mode ? 20 : 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cb_addr_gen.md
Name: cb_addr_gen

Overview:
- Upstream address sequencer for the CB (covariance block) bank-shift stage.
- Walks a rectangular sub-block of the CB matrix, row by row and L-column group by group.
- Emits per cycle the BANK0 base address, the L-bit bank-enable mask and the first-group-of-row flag, which drive the CB address shift stage's din, CB_en and group_cnt_0.
- Controlled by a start/busy/done handshake from the EKF top-level controller.

Parameters:
- L, 4, number of CB banks (columns per group).
- CB_AW, 19, CB address width.
- ROW_LEN, 10, address stride between consecutive matrix rows (groups per full row).
- RW, 10, width of row_num.
- CW, 12, width of col_num (element columns).

Ports:
- clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- base_addr  in  CB_AW  BANK0 address of the first group of the first row; sampled on start.
- row_num  in  RW  rows to walk; sampled on start.
- col_num  in  CW  element columns per row; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last group is issued.
- dout  out  CB_AW  BANK0 group address (feeds din of the shift stage).
- CB_en  out  L  bank enables for the current group; all-zero means no issue.
- group_cnt_0  out  1  high on group 0 of each row.

Behaviour:
- Reset (sys_rst==0 at clk edge): state=IDLE; busy, done, dout, CB_en, group_cnt_0 and all counters cleared. Reset mid-operation aborts immediately; no done pulse is issued.
- FSM has three states: IDLE, RUN, FIN.
  - IDLE: on start, latch the inputs.
    - If row_num==0 or col_num==0, go to FIN (no issue cycles).
    - Otherwise go to RUN with row_addr=base_addr, grp=0, row=0.
  - RUN: issue exactly one group per cycle.
    - dout = row_addr + grp.
    - group_cnt_0 = (grp==0).
    - CB_en = all ones, except on the last group of a row (grp == ngrp-1) where CB_en = (1<<rem)-1, rem = col_num mod L. If rem==0, CB_en is all ones.
    - ngrp = ceil(col_num/L), computed once at start.
    - col_num above ROW_LEN*L saturates to ROW_LEN*L.
  - Row advance: when grp==ngrp-1, set grp=0, row_addr += ROW_LEN and row++. When row==row_num-1 also holds, go to FIN.
  - FIN: done=1 for one cycle, busy=0, then return to IDLE.
- Latency: first issue cycle is 1 clk after start is sampled. Total issue cycles = row_num*ngrp, with no bubbles.
- Outside RUN: CB_en=0 and group_cnt_0=0. dout holds its last value (don't-care).
- start while busy or in FIN is ignored.
- Address arithmetic is unsigned modulo 2^CB_AW and wraps silently.
- busy is registered: it asserts in the first RUN/FIN cycle and deasserts in the same cycle done pulses.

Optional Feature:
- Macro: CB_ADDR_GEN_STALL_EN.
- Defined: adds input port stall (1 bit). While stall==1 in RUN, counters, row_addr and state hold, and CB_en is forced to 0. group_cnt_0 and dout hold. Issue resumes at the same group when stall drops. stall is ignored in IDLE and FIN.
- Undefined: no stall port; issue is never interrupted.

Decomposition:
- Shared package cb_pkg:
  - FSM state encoding (IDLE/RUN/FIN).
  - Default L, CB_AW and ROW_LEN constants.
  - Function ceil_div_l(col_num) and function tail_mask(rem) returning the L-bit mask.
- One natural sub-module: cb_tail_mask. It is combinational, computing ngrp and the last-group mask from col_num. It is instantiated once and registered at start.

Test Plan:
- L=4, ROW_LEN=10, base=100, row_num=2, col_num=6 -> (dout,CB_en,g0) sequence (100,1111,1),(101,0011,0),(110,1111,1),(111,0011,0). Then done pulses for 1 cycle and busy spans 5 cycles.
- base=0, row_num=3, col_num=4 -> (0,1111,1),(10,1111,1),(20,1111,1), then done. Every group is both first and last of its row.
- row_num=0 or col_num=0 -> no CB_en activity; done pulses 2 cycles after start.
- base=2^19-1, row_num=1, col_num=8 -> dout sequence 524287 then 0 (wrap), CB_en=1111 both cycles.
- Assert sys_rst=0 during the 2nd issue cycle of the first test -> next cycle all outputs are 0, state is IDLE, no done. A new start is accepted after reset releases.
- With CB_ADDR_GEN_STALL_EN defined, stall=1 for 3 cycles after the first issue -> CB_en=0 for those cycles, then the sequence resumes at (101,0011,0). Total cycles grow by 3.
